// File: rtl/gcd_arbiter.sv
// Round-robin arbiter sharing one GCD unit among four requesters.
// Define GCD_ARB_TIMEOUT_EN to abort a WAIT after TIMEOUT cycles.
module gcd_arbiter #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [3:0]         REQ,
  input  logic [4*WIDTH-1:0] A,
  input  logic [4*WIDTH-1:0] B,
  output logic [3:0]         ACK,
  output logic [WIDTH-1:0]   Y,
  output logic               ERROR,
  output logic               BUSY,
  output logic [1:0]         GRANT_ID,
  output logic               GCD_START,
  output logic [WIDTH-1:0]   GCD_A,
  output logic [WIDTH-1:0]   GCD_B,
  input  logic               GCD_DONE,
  input  logic [WIDTH-1:0]   GCD_Y,
  input  logic               GCD_ERROR
);

  typedef enum logic [1:0] {
    IDLE, ISSUE, WAIT, RESP
  } state_t;

  state_t           state_q;
  logic [1:0]       ptr_q;
  logic [1:0]       gid_q;
  logic             start_q;
  logic             err_q;
  logic             busy_q;
  logic [3:0]       ack_q;
  logic [WIDTH-1:0] ga_q;
  logic [WIDTH-1:0] gb_q;
  logic [WIDTH-1:0] y_q;

  logic             found;
  logic [1:0]       pick;
  logic [1:0]       idx;
  logic             tmo;

  // first requester at or above ptr_q, wrapping
  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    idx   = ptr_q;
    for (int i = 0; i < 4; i++) begin
      idx = ptr_q + 2'(i);
      if (!found && REQ[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

`ifdef GCD_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q;

  assign tmo = (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
    end else if (state_q == ISSUE) begin
      cnt_q <= '0;
    end else if (state_q == WAIT && !tmo) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign tmo = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gid_q   <= '0;
      start_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      ack_q   <= '0;
      ga_q    <= '0;
      gb_q    <= '0;
      y_q     <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (found) begin
            ga_q    <= A[int'(pick)*WIDTH +: WIDTH];
            gb_q    <= B[int'(pick)*WIDTH +: WIDTH];
            gid_q   <= pick;
            start_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          start_q <= 1'b0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (GCD_DONE) begin
            y_q     <= GCD_Y;
            err_q   <= GCD_ERROR;
            ack_q   <= 4'b0001 << gid_q;
            ptr_q   <= gid_q + 2'd1;
            state_q <= RESP;
          end else if (tmo) begin
            y_q     <= '0;
            err_q   <= 1'b1;
            ack_q   <= 4'b0001 << gid_q;
            ptr_q   <= gid_q + 2'd1;
            state_q <= RESP;
          end
        end
        RESP: begin
          ack_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ACK       = ack_q;
  assign Y         = y_q;
  assign ERROR     = err_q;
  assign BUSY      = busy_q;
  assign GRANT_ID  = gid_q;
  assign GCD_START = start_q;
  assign GCD_A     = ga_q;
  assign GCD_B     = gb_q;

endmodule

// File: tb/tb_gcd_arbiter.sv
// Scoreboard bench for gcd_arbiter with an abstract round-robin model
// and a behavioural GCD unit of random latency.
module tb_gcd_arbiter;
  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic [3:0]   REQ = '0;
  logic [4*W-1:0] A = '0;
  logic [4*W-1:0] B = '0;
  logic [3:0]   ACK;
  logic [W-1:0] Y;
  logic         ERROR;
  logic         BUSY;
  logic [1:0]   GRANT_ID;
  logic         GCD_START;
  logic [W-1:0] GCD_A;
  logic [W-1:0] GCD_B;
  logic         GCD_DONE = 1'b0;
  logic [W-1:0] GCD_Y = '0;
  logic         GCD_ERROR = 1'b0;

  gcd_arbiter #(.WIDTH(W), .TIMEOUT(255)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .A(A), .B(B),
    .ACK(ACK), .Y(Y), .ERROR(ERROR), .BUSY(BUSY),
    .GRANT_ID(GRANT_ID), .GCD_START(GCD_START),
    .GCD_A(GCD_A), .GCD_B(GCD_B), .GCD_DONE(GCD_DONE),
    .GCD_Y(GCD_Y), .GCD_ERROR(GCD_ERROR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0] id;
    logic [7:0] y;
    logic       err;
  } resp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
  } iss_t;

  resp_t      q_resp[$];
  iss_t       q_iss[$];
  logic [7:0] ops_a[4][$];
  logic [7:0] ops_b[4][$];
  int         checks = 0;
  int         failures = 0;
  int         m_ptr = 0;
  bit         hang = 0;
  bit         spur = 0;
  int         busy_cnt = 0;
  logic [7:0] ca, cb;
  resp_t      mon_r;
  iss_t       gi;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    failures++;
    $display("FAIL %s", nm);
  endtask

  function automatic logic [7:0] gcd_f(input logic [7:0] a,
                                       input logic [7:0] b);
    logic [7:0] x = a, z = b, t;
    while (z != 0) begin
      t = x % z;
      x = z;
      z = t;
    end
    return x;
  endfunction

  task automatic push_op(input int i, input logic [7:0] a,
                         input logic [7:0] b);
    ops_a[i].push_back(a);
    ops_b[i].push_back(b);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " start"}, 32'(GCD_START), 0);
    chk({tag, " gcd_a"}, 32'(GCD_A), 0);
    chk({tag, " gcd_b"}, 32'(GCD_B), 0);
    chk({tag, " ack"}, 32'(ACK), 0);
    chk({tag, " y"}, 32'(Y), 0);
    chk({tag, " error"}, 32'(ERROR), 0);
    chk({tag, " busy"}, 32'(BUSY), 0);
    chk({tag, " grant"}, 32'(GRANT_ID), 0);
  endtask

  // Model: each grant goes to the first pending requester from ptr.
  task automatic run_burst();
    int c[4];
    int tot = 0;
    int g;
    int budget;
    bit left;
    for (int i = 0; i < 4; i++) begin
      c[i] = ops_a[i].size();
      tot += c[i];
    end
    while (tot > 0) begin
      resp_t r;
      iss_t  s;
      int    k;
      g = -1;
      for (int n = 0; n < 4; n++) begin
        int j = (m_ptr + n) % 4;
        if (g < 0 && c[j] > 0) g = j;
      end
      k = ops_a[g].size() - c[g];
      s.a = ops_a[g][k];
      s.b = ops_b[g][k];
      r.id = 2'(g);
      r.err = (s.a == 0 || s.b == 0);
      r.y = r.err ? 8'd0 : gcd_f(s.a, s.b);
      q_iss.push_back(s);
      q_resp.push_back(r);
      c[g]--;
      tot--;
      m_ptr = (g + 1) % 4;
    end
    @(negedge CLK);
    for (int i = 0; i < 4; i++) begin
      REQ[i] = ops_a[i].size() > 0;
      if (ops_a[i].size() > 0) begin
        A[i*W +: W] = ops_a[i][0];
        B[i*W +: W] = ops_b[i][0];
      end
    end
    budget = 0;
    left = 1;
    while (left && budget < 500) begin
      @(negedge CLK);
      budget++;
      for (int i = 0; i < 4; i++) begin
        if (ACK[i] && ops_a[i].size() > 0) begin
          void'(ops_a[i].pop_front());
          void'(ops_b[i].pop_front());
          if (ops_a[i].size() == 0) begin
            REQ[i] = 1'b0;
          end else begin
            A[i*W +: W] = ops_a[i][0];
            B[i*W +: W] = ops_b[i][0];
          end
        end
      end
      left = 0;
      for (int i = 0; i < 4; i++)
        if (ops_a[i].size() > 0) left = 1;
    end
    if (left) fail("burst timeout");
    repeat (4) @(negedge CLK);
    chk("drain resp", q_resp.size(), 0);
  endtask

  // Response monitor
  initial forever begin
    @(negedge CLK);
    if (!RST && ACK != 0) begin
      if (q_resp.size() == 0) begin
        fail("unexpected ack");
      end else begin
        mon_r = q_resp.pop_front();
        chk("ack", 32'(ACK), 32'(4'b0001 << mon_r.id));
        chk("y", 32'(Y), 32'(mon_r.y));
        chk("error", 32'(ERROR), 32'(mon_r.err));
        chk("grant_id", 32'(GRANT_ID), 32'(mon_r.id));
        chk("busy at ack", 32'(BUSY), 1);
      end
    end
  end

  // Behavioural GCD unit; also checks issued operands
  initial forever begin
    @(negedge CLK);
    GCD_DONE = 1'b0;
    GCD_Y = 8'($urandom);
    GCD_ERROR = 1'($urandom);
    if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) begin
        GCD_DONE = 1'b1;
        GCD_ERROR = (ca == 0 || cb == 0);
        GCD_Y = GCD_ERROR ? 8'd0 : gcd_f(ca, cb);
      end
    end else if (spur) begin
      GCD_DONE = 1'b1;
      GCD_Y = 8'h5A;
      GCD_ERROR = 1'b1;
    end
    if (GCD_START && !RST) begin
      if (q_iss.size() == 0) begin
        fail("unexpected start");
      end else begin
        gi = q_iss.pop_front();
        chk("gcd_a", 32'(GCD_A), 32'(gi.a));
        chk("gcd_b", 32'(GCD_B), 32'(gi.b));
      end
      ca = GCD_A;
      cb = GCD_B;
      busy_cnt = hang ? 0 : int'($urandom_range(1, 6));
    end
  end

  initial begin
    #2000000;
    $fatal(1, "FAIL watchdog timeout");
  end

  initial begin
    #12;
    chk_zero("reset");
    @(negedge CLK);
    RST = 1'b0;

    push_op(0, 8'd21, 8'd6);
    run_burst();

    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    m_ptr = 0;
    push_op(0, 8'd21, 8'd6);
    push_op(1, 8'd75, 8'd60);
    push_op(2, 8'd17, 8'd5);
    push_op(3, 8'd48, 8'd36);
    run_burst();

    push_op(0, 8'd12, 8'd18);
    push_op(0, 8'd35, 8'd14);
    push_op(2, 8'd100, 8'd75);
    push_op(2, 8'd81, 8'd27);
    run_burst();

    push_op(1, 8'd0, 8'd5);
    run_burst();

    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 4; i++) begin
        int n = int'($urandom_range(0, 2));
        for (int k = 0; k < n; k++)
          push_op(i, 8'($urandom_range(0, 255)),
                  8'($urandom_range(1, 255)));
      end
      run_burst();
    end

    hang = 1;
    begin
      iss_t s;
      s.a = 8'd9;
      s.b = 8'd3;
      q_iss.push_back(s);
    end
    @(negedge CLK);
    REQ = 4'b0010;
    A[15:8] = 8'd9;
    B[15:8] = 8'd3;
    repeat (300) @(negedge CLK);
    chk("hang busy", 32'(BUSY), 1);
    chk("hang grant", 32'(GRANT_ID), 1);
    chk("hang gcd_a", 32'(GCD_A), 9);
    #1 RST = 1'b1;
    #1 chk_zero("mid reset");
    @(negedge CLK);
    REQ = '0;
    hang = 0;
    @(negedge CLK);
    RST = 1'b0;
    m_ptr = 0;
    repeat (3) @(negedge CLK);
    spur = 1;
    repeat (2) @(negedge CLK);
    spur = 0;
    repeat (4) @(negedge CLK);
    chk("spurious busy", 32'(BUSY), 0);
    chk("spurious ack", 32'(ACK), 0);
    chk("no stray issue", q_iss.size(), 0);

    push_op(3, 8'd40, 8'd25);
    run_burst();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gcd_arbiter.md
# gcd_arbiter

Round-robin arbiter and sequencer that shares one `GCD` unit among four requesters. It collects `REQ`/operand pairs and issues one `START` pulse per granted request to the GCD. It waits for the GCD's `DONE`, then returns `Y`/`ERROR` to the granted requester with a one-cycle `ACK`. It sits between the client blocks and the single GCD instance; the GCD's active-low `RST_N` is driven from the inverted `RST` at top level.

## Interface
- `WIDTH`, 8, operand/result width; must match the GCD.
- `TIMEOUT`, 255, max WAIT cycles before abort; used only with `GCD_ARB_TIMEOUT_EN`.
- `CLK`  in  1  single clock, rising edge.
- `RST`  in  1  reset, asynchronous, active-high.
- `REQ`  in  4  per-requester request level.
- `A`  in  4*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH].
- `B`  in  4*WIDTH  operand B, same packing.
- `ACK`  out  4  one-hot, one-cycle completion pulse.
- `Y`  out  WIDTH  result, valid while `ACK` is nonzero; held until the next completion.
- `ERROR`  out  1  error flag, valid with `ACK`.
- `BUSY`  out  1  high in ISSUE/WAIT/RESP.
- `GRANT_ID`  out  2  index of the current or last grantee.
- `GCD_START`  out  1  one-cycle start pulse to the GCD.
- `GCD_A`, `GCD_B`  out  WIDTH  operands to the GCD; registered and held from ISSUE until the next grant.
- `GCD_DONE`  in  1  GCD completion.
- `GCD_Y`  in  WIDTH  GCD result.
- `GCD_ERROR`  in  1  GCD error.

## Operation
- States: IDLE, ISSUE, WAIT, RESP. Reset state is IDLE.
- **IDLE**
  - If `REQ` is nonzero, pick the first set bit searching upward from `PTR`, wrapping mod 4.
  - Latch that requester's A/B into `GCD_A`/`GCD_B`, set `GRANT_ID`, and go to ISSUE.
  - If `REQ` is zero, stay in IDLE.
- **ISSUE**
  - `GCD_START`=1 for exactly this cycle.
  - Go to WAIT.
- **WAIT**
  - `GCD_START`=0.
  - On `GCD_DONE`=1: register `Y`←`GCD_Y` and `ERROR`←`GCD_ERROR`, set `ACK[GRANT_ID]`=1, set `PTR`←`GRANT_ID`+1 mod 4, and go to RESP.
- **RESP**
  - `ACK` is high for this cycle only.
  - Next state is always IDLE. `REQ` is ignored in this state.
- **Requester protocol**
  - Hold `REQ` and operands stable until `ACK` is seen, then drop `REQ` at the next edge.
  - `REQ` still high when IDLE is next sampled counts as a new request.
  - `REQ` dropped before `ACK`: the operation still completes and `ACK` is still issued; there is no cancel.
- **Arithmetic:** none. Results pass through unmodified.
- **Boundary conditions**
  - `GCD_DONE` in IDLE, ISSUE or RESP is ignored.
  - All four `REQ` asserted together: service order is 0,1,2,3 starting from `PTR`=0.
  - A continuously asserted `REQ` cannot starve the others, because `PTR` advances past each grantee.
  - `RST` mid-operation: state returns to IDLE immediately, `PTR`=0, all outputs are cleared, and no `ACK` is issued for the aborted request.

## Timing
- Reset values: `GCD_START`=0, `GCD_A`=`GCD_B`=0, `ACK`=0, `Y`=0, `ERROR`=0, `BUSY`=0, `GRANT_ID`=0, `PTR`=0.
- `REQ` sampled in IDLE at edge k: ISSUE (`GCD_START`=1) in cycle k+1, WAIT from k+2.
- `GCD_DONE` sampled at edge d: `ACK`/`Y`/`ERROR` valid in cycle d+1, IDLE at d+2.
- Overhead is 3 cycles plus GCD latency; the minimum gap between consecutive `GCD_START` pulses is GCD latency + 3.
- All outputs are registered.

## Configuration
- `GCD_ARB_TIMEOUT_EN` defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches `TIMEOUT` with no `GCD_DONE`, go to RESP with `Y`=0, `ERROR`=1, `ACK[GRANT_ID]`=1, and advance `PTR` as for a normal completion.
  - A `GCD_DONE` arriving afterwards is ignored.
- Not defined:
  - There is no counter; WAIT persists until `GCD_DONE` or `RST`.
  - `TIMEOUT` is unused.

## Test plan
- `REQ`=0001 with A0=21, B0=6 → one `GCD_START` pulse with `GCD_A`=21 and `GCD_B`=6; after `GCD_DONE`, `ACK`=0001 for 1 cycle with `Y`=3 and `ERROR`=0.
- `REQ`=1111 with operand pairs (21,6), (75,60), (17,5), (48,36) → `ACK` order 0001, 0010, 0100, 1000 with `Y`=3, 15, 1, 12.
- `REQ[0]` and `REQ[2]` re-asserted immediately after each `ACK` → grants alternate 0,2,0,2; never 0,0.
- `REQ[1]` with A=0, B=5, GCD returns `ERROR`=1 → `ACK`=0010, `ERROR`=1.
- `RST` pulsed during WAIT → all outputs 0 asynchronously and no `ACK`; a spurious `GCD_DONE` in IDLE is ignored; the next `REQ`=1000 is granted with `GRANT_ID`=3.
- `GCD_ARB_TIMEOUT_EN` with `TIMEOUT`=16 and a GCD model that never asserts `DONE` → `ACK` 16 cycles after WAIT entry, `ERROR`=1, `Y`=0; without the macro, `BUSY` stays 1.
